// File: rtl/retire_pkg.sv
// retire_pkg: shared types, widths and helpers for the commit stage.
//   - W (retire width) is 4 and PHYS_REGS (physical registers) is 64.
//   - rob_entry_t : one ROB head-window entry (ROB_ENTRY).
//   - rob_idx_t   : ROB index (ROB_IDX), addr_t : fetch address (ADDR).
//   - retire_state_t : commit FSM states.
//   - is_mispred() : branch outcome disagrees with the prediction.
package retire_pkg;

  localparam int W          = 4;
  localparam int PHYS_REGS  = 64;

  localparam int ARCH_COUNT = 32;
  localparam int ARW        = $clog2(ARCH_COUNT);
  localparam int PRW        = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1;
  localparam int ROB_IDX_W  = 5;
  localparam int ADDR_W     = 32;
  localparam int CNTW       = $clog2(W + 1);
  localparam int SLW        = (W > 1) ? $clog2(W) : 1;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic           complete;
    logic           halt;
    logic           branch;
    logic           pred_taken;
    logic           branch_taken;
    addr_t          pc;
    addr_t          pred_target;
    addr_t          branch_target;
    logic [ARW-1:0] arch_rd;
    logic [PRW-1:0] phys_rd;
    logic [PRW-1:0] prev_phys_rd;
    rob_idx_t       rob_idx;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RS_RUN,
    RS_RECOVER,
    RS_HALTED
  } retire_state_t;

  // A taken branch also mispredicts when it went to a different target.
  function automatic logic is_mispred(input rob_entry_t e);
    return e.branch &&
           ((e.pred_taken != e.branch_taken) ||
            (e.branch_taken && (e.pred_target != e.branch_target)));
  endfunction

endpackage

// File: rtl/retire_scan.sv
// retire_scan: combinational in-order scan of the ROB head window.
//   Slot W-1 is the oldest. The scan retires consecutive valid+complete
//   slots and stops after a mispredicted branch or a halt (both of which
//   retire themselves), or at the first slot that cannot retire.
// Ports:
//   head_entries / head_valids : ROB head window
//   retire_mask                : slots that retire this cycle
//   retire_cnt                 : number of retiring slots
//   mispred_slot/mispred_valid : the retiring mispredicted branch, if any
//   halt_hit                   : a halt retires this cycle
module retire_scan
  import retire_pkg::*;
(
  input  rob_entry_t [W-1:0] head_entries,
  input  logic [W-1:0]       head_valids,
  output logic [W-1:0]       retire_mask,
  output logic [CNTW-1:0]    retire_cnt,
  output logic [SLW-1:0]     mispred_slot,
  output logic               mispred_valid,
  output logic               halt_hit
);

  logic stop;
  logic unused_fields;

  // NOTE: every variable gets a default before the loop; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    retire_mask   = '0;
    retire_cnt    = '0;
    mispred_slot  = '0;
    mispred_valid = 1'b0;
    halt_hit      = 1'b0;
    stop          = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!stop) begin
        if (head_valids[i] && head_entries[i].complete) begin
          retire_mask[i] = 1'b1;
          retire_cnt     = retire_cnt + CNTW'(1);
          if (is_mispred(head_entries[i])) begin
            mispred_valid = 1'b1;
            mispred_slot  = SLW'(i);
            stop          = 1'b1;
          end
          if (head_entries[i].halt) begin
            halt_hit = 1'b1;
            stop     = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

  // Payload fields are consumed by retire_ctrl, not by the scan.
  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < W; i++) begin
      unused_fields = unused_fields ^ (^{head_entries[i].pc, head_entries[i].arch_rd,
                                         head_entries[i].phys_rd, head_entries[i].prev_phys_rd,
                                         head_entries[i].rob_idx});
    end
  end

endmodule

// File: rtl/retire_ctrl.sv
// retire_ctrl: commit stage between the ROB head window and the arch map,
//   freelist and fetch. Retires up to W in-order entries per cycle with
//   0-cycle latency, truncates at the first mispredicted branch, then blocks
//   retire for RECOVER_CYC cycles (RECOVER); a retired halt is sticky (HALTED).
// Ports:
//   clock, reset (synchronous, active-high)
//   head_entries / head_valids       : ROB head window (slot W-1 oldest)
//   rob_retire_cnt                   : entries popped from the ROB
//   rob_mispredict / rob_mispred_idx : flush younger than this ROB index
//   redirect_valid / redirect_pc     : fetch redirect
//   BPRecoverEN                      : map table precise->spec copy
//   Arch_Retire_EN/AR/Tnew_in        : arch map commit per slot
//   FL_RetireEN / FL_RetireReg       : freelist returns per slot
//   halted                           : sticky halt indication
// Build option RETIRE_PERF_EN adds perf_retired, perf_mispred, perf_stall.
module retire_ctrl
  import retire_pkg::*;
#(
  parameter int RECOVER_CYC = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  rob_entry_t [W-1:0]      head_entries,
  input  logic [W-1:0]            head_valids,
  output logic [CNTW-1:0]         rob_retire_cnt,
  output logic                    rob_mispredict,
  output rob_idx_t                rob_mispred_idx,
  output logic                    redirect_valid,
  output addr_t                   redirect_pc,
  output logic                    BPRecoverEN,
  output logic [W-1:0]            Arch_Retire_EN,
  output logic [W-1:0][ARW-1:0]   Arch_Retire_AR,
  output logic [W-1:0][PRW-1:0]   Arch_Retire_Tnew_in,
  output logic [W-1:0]            FL_RetireEN,
  output logic [W-1:0][PRW-1:0]   FL_RetireReg,
  output logic                    halted
`ifdef RETIRE_PERF_EN
  ,
  output logic [63:0]             perf_retired,
  output logic [31:0]             perf_mispred,
  output logic [31:0]             perf_stall
`endif
);

  localparam int RCW = $clog2(RECOVER_CYC + 1);

  retire_state_t  state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  logic [W-1:0]    scan_mask;
  logic [CNTW-1:0] scan_cnt;
  logic [SLW-1:0]  scan_mp_slot;
  logic            scan_mp_valid;
  logic            scan_halt;
  rob_entry_t      mp_entry;

  retire_scan u_scan (
    .head_entries  (head_entries),
    .head_valids   (head_valids),
    .retire_mask   (scan_mask),
    .retire_cnt    (scan_cnt),
    .mispred_slot  (scan_mp_slot),
    .mispred_valid (scan_mp_valid),
    .halt_hit      (scan_halt)
  );

  assign mp_entry = head_entries[scan_mp_slot];

  always_comb begin
    state_d             = state_q;
    rcnt_d              = rcnt_q;
    rob_retire_cnt      = '0;
    rob_mispredict      = 1'b0;
    rob_mispred_idx     = '0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    BPRecoverEN         = 1'b0;
    Arch_Retire_EN      = '0;
    Arch_Retire_AR      = '0;
    Arch_Retire_Tnew_in = '0;
    FL_RetireEN         = '0;
    FL_RetireReg        = '0;
    halted              = 1'b0;
    // Outputs stay quiet during reset so the ROB never pops a stale window.
    if (!reset) begin
      unique case (state_q)
        RS_RUN: begin
          rob_retire_cnt = scan_cnt;
          for (int i = 0; i < W; i++) begin
            // r0 has no mapping to commit or physical register to free.
            if (scan_mask[i] && (head_entries[i].arch_rd != '0)) begin
              Arch_Retire_EN[i]      = 1'b1;
              Arch_Retire_AR[i]      = head_entries[i].arch_rd;
              Arch_Retire_Tnew_in[i] = head_entries[i].phys_rd;
              FL_RetireEN[i]         = 1'b1;
              FL_RetireReg[i]        = head_entries[i].prev_phys_rd;
            end
          end
          if (scan_mp_valid) begin
            rob_mispredict  = 1'b1;
            rob_mispred_idx = mp_entry.rob_idx;
            redirect_valid  = 1'b1;
            redirect_pc     = mp_entry.branch_taken ? mp_entry.branch_target
                                                    : mp_entry.pc + ADDR_W'(4);
            state_d         = RS_RECOVER;
            rcnt_d          = RCW'(RECOVER_CYC);
          end
          // A halt wins over recovery; the mispredict pulses above still fire.
          if (scan_halt) begin
            state_d = RS_HALTED;
          end
        end
        RS_RECOVER: begin
          // The copy waits one cycle so the branch's own commit lands first.
          BPRecoverEN = (rcnt_q == RCW'(RECOVER_CYC));
          rcnt_d      = rcnt_q - RCW'(1);
          if (rcnt_q == RCW'(1)) begin
            state_d = RS_RUN;
          end
        end
        RS_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_d = RS_RUN;
        end
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RS_RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

`ifdef RETIRE_PERF_EN
  logic [63:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_retired_d = perf_retired_q + 64'(rob_retire_cnt);
    perf_mispred_d = perf_mispred_q + 32'(rob_mispredict);
    perf_stall_d   = perf_stall_q;
    if ((state_q == RS_RUN) && head_valids[W-1] && (rob_retire_cnt == '0)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_mispred_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_mispred_q <= perf_mispred_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_mispred = perf_mispred_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
